// File: rtl/sw_alloc_rr_vc.sv
// Separable input-first switch allocator: round-robin VC pick per input, then round-robin input pick per output, with wormhole output locks.
// Latency: inputs sampled at edge N, grant/crossbar outputs registered and valid during cycle N+1.
// Backpressure: out_ready=0 makes every request to that output ineligible; locks and pointers hold until it returns.
module sw_alloc_rr_vc #(
  parameter int PORT_NUM = 5,
  parameter int VC_NUM   = 2,
  parameter int SEL_W    = $clog2(PORT_NUM),
  parameter int VC_W     = (VC_NUM > 1 ? $clog2(VC_NUM) : 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORT_NUM*VC_NUM-1:0]       req,
  input  logic [PORT_NUM*VC_NUM*SEL_W-1:0] route_sel,
  input  logic [PORT_NUM*VC_NUM-1:0]       tail,
  input  logic [PORT_NUM-1:0]              out_ready,
  output logic [PORT_NUM-1:0]              grant,
  output logic [PORT_NUM*VC_W-1:0]         grant_vc,
  output logic [PORT_NUM-1:0]              out_valid,
  output logic [PORT_NUM*SEL_W-1:0]        xbar_sel,
  output logic                             route_err
);

  localparam int              NREQ     = PORT_NUM * VC_NUM;
  localparam logic [SEL_W:0]  PORT_LIM = PORT_NUM[SEL_W:0];

  // Round-robin pointers and per-output wormhole lock state
  logic [PORT_NUM-1:0][VC_W-1:0]  vc_ptr;
  logic [PORT_NUM-1:0][SEL_W-1:0] in_ptr;
  logic [PORT_NUM-1:0]            lock_vld;
  logic [PORT_NUM-1:0][SEL_W-1:0] lock_p;
  logic [PORT_NUM-1:0][VC_W-1:0]  lock_v;

  // Combinational allocation results
  logic [NREQ-1:0]                elig;
  logic [NREQ-1:0]                bad;
  logic [PORT_NUM-1:0]            s1_vld;
  logic [PORT_NUM-1:0][VC_W-1:0]  s1_vc;
  logic [PORT_NUM-1:0][SEL_W-1:0] s1_out;
  logic [PORT_NUM-1:0]            ov_n;
  logic [PORT_NUM-1:0][SEL_W-1:0] xs_n;
  logic [PORT_NUM-1:0]            gnt_n;
  logic [PORT_NUM-1:0][VC_W-1:0]  gv_n;
  logic [PORT_NUM-1:0]            gt_n;
  int                             s1_idx;
  int                             s2_idx;

  function automatic logic [SEL_W-1:0] route_of(input int i);
    return route_sel[i*SEL_W +: SEL_W];
  endfunction

  // Eligibility: valid route, downstream ready, and output lock idle or owned by this input-VC
  always_comb begin
    elig = '0;
    bad  = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        if ({1'b0, route_of(p*VC_NUM+v)} >= PORT_LIM) begin
          bad[p*VC_NUM+v] = 1'b1;
        end
        for (int o = 0; o < PORT_NUM; o++) begin
          if (route_of(p*VC_NUM+v) == SEL_W'(o) && out_ready[o] &&
              (!lock_vld[o] || (lock_p[o] == SEL_W'(p) && lock_v[o] == VC_W'(v)))) begin
            elig[p*VC_NUM+v] = req[p*VC_NUM+v];
          end
        end
      end
    end
  end

  // Stage 1: per input, first eligible VC at or after vc_ptr
  always_comb begin
    s1_vld = '0;
    s1_vc  = '0;
    s1_out = '0;
    s1_idx = 0;
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int k = 0; k < VC_NUM; k++) begin
        s1_idx = int'(vc_ptr[p]) + k;
        if (s1_idx >= VC_NUM) s1_idx = s1_idx - VC_NUM;
        if (!s1_vld[p] && elig[p*VC_NUM+s1_idx]) begin
          s1_vld[p] = 1'b1;
          s1_vc[p]  = VC_W'(s1_idx);
          s1_out[p] = route_of(p*VC_NUM+s1_idx);
        end
      end
    end
  end

  // Stage 2: per output, first stage-1 winner targeting it at or after in_ptr
  always_comb begin
    ov_n   = '0;
    xs_n   = '0;
    gnt_n  = '0;
    gv_n   = '0;
    gt_n   = '0;
    s2_idx = 0;
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int k = 0; k < PORT_NUM; k++) begin
        s2_idx = int'(in_ptr[o]) + k;
        if (s2_idx >= PORT_NUM) s2_idx = s2_idx - PORT_NUM;
        if (!ov_n[o] && s1_vld[s2_idx] && s1_out[s2_idx] == SEL_W'(o)) begin
          ov_n[o]       = 1'b1;
          xs_n[o]       = SEL_W'(s2_idx);
          gnt_n[s2_idx] = 1'b1;
          gv_n[o]       = s1_vc[s2_idx];
          gt_n[o]       = tail[s2_idx*VC_NUM + int'(s1_vc[s2_idx])];
        end
      end
    end
  end

  // Register outputs, advance pointers on final grants, and run the per-output lock FSM
  always_ff @(posedge clk) begin
    if (!rst) begin
      grant     <= '0;
      grant_vc  <= '0;
      out_valid <= '0;
      xbar_sel  <= '0;
      route_err <= 1'b0;
      vc_ptr    <= '0;
      in_ptr    <= '0;
      lock_vld  <= '0;
      lock_p    <= '0;
      lock_v    <= '0;
    end else begin
      grant     <= gnt_n;
      out_valid <= ov_n;
      xbar_sel  <= xs_n;
      route_err <= route_err | (|(req & bad));
      for (int p = 0; p < PORT_NUM; p++) begin
        grant_vc[p*VC_W +: VC_W] <= gnt_n[p] ? s1_vc[p] : '0;
        if (gnt_n[p]) begin
          vc_ptr[p] <= (s1_vc[p] == VC_W'(VC_NUM-1)) ? '0 : s1_vc[p] + VC_W'(1);
        end
      end
      for (int o = 0; o < PORT_NUM; o++) begin
        if (ov_n[o]) begin
          in_ptr[o] <= (xs_n[o] == SEL_W'(PORT_NUM-1)) ? '0 : xs_n[o] + SEL_W'(1);
          // Only the owner can be granted while locked, so a granted tail always releases
          if (!lock_vld[o]) begin
            if (!gt_n[o]) begin
              lock_vld[o] <= 1'b1;
              lock_p[o]   <= xs_n[o];
              lock_v[o]   <= gv_n[o];
            end
          end else if (gt_n[o]) begin
            lock_vld[o] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sw_alloc_rr_vc.sv
// Directed bench for sw_alloc_rr_vc: reset, fairness, wormhole locking, VC round-robin, backpressure, bad routes.
// Inputs change 1 time unit after the rising edge; outputs are checked at the same point, reflecting the edge just taken.
// All expectations are hand-derived from the allocator rules with pointers starting at 0 after each reset.
module tb_sw_alloc_rr_vc;

  localparam int P  = 5;
  localparam int V  = 2;
  localparam int S  = 3;
  localparam int VW = 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [P*V-1:0]   req = '0;
  logic [P*V*S-1:0] route_sel = '0;
  logic [P*V-1:0]   tail = '0;
  logic [P-1:0]     out_ready = '1;
  logic [P-1:0]     grant;
  logic [P*VW-1:0]  grant_vc;
  logic [P-1:0]     out_valid;
  logic [P*S-1:0]   xbar_sel;
  logic             route_err;

  int vectors = 0;
  int miscompares = 0;

  sw_alloc_rr_vc #(.PORT_NUM(P), .VC_NUM(V)) dut (
    .clk(clk), .rst(rst), .req(req), .route_sel(route_sel), .tail(tail),
    .out_ready(out_ready), .grant(grant), .grant_vc(grant_vc),
    .out_valid(out_valid), .xbar_sel(xbar_sel), .route_err(route_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    req = '0;
    route_sel = '0;
    tail = '0;
  endtask

  task automatic put(input int p, input int v, input int o, input logic t);
    req[p*V+v] = 1'b1;
    route_sel[(p*V+v)*S +: S] = S'(o);
    tail[p*V+v] = t;
  endtask

  task automatic do_reset();
    clr();
    out_ready = '1;
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  function automatic logic [S-1:0] xs(input int o);
    return xbar_sel[o*S +: S];
  endfunction

  function automatic logic [VW-1:0] gvc(input int p);
    return grant_vc[p*VW +: VW];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset held 2 cycles with every VC requesting output 0
    for (int i = 0; i < P*V; i++) begin
      req[i] = 1'b1;
      tail[i] = 1'b1;
    end
    rst = 1'b0;
    tick();
    tick();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_grant_vc", 32'(grant_vc), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_xbar_sel", 32'(xbar_sel), 32'h0);
    check("rst_route_err", 32'(route_err), 32'h0);
    rst = 1'b1;
    tick();
    check("rel_grant0", 32'(grant), 32'h01);
    check("rel_out_valid0", 32'(out_valid), 32'h01);
    check("rel_gvc0", 32'(gvc(0)), 32'h0);
    tick();
    check("rel_grant1", 32'(grant), 32'h02);
    check("rel_xs0_1", 32'(xs(0)), 32'h1);

    // Fairness: inputs 0,1,2 VC0 all single-flit packets to output 3
    do_reset();
    put(0, 0, 3, 1'b1);
    put(1, 0, 3, 1'b1);
    put(2, 0, 3, 1'b1);
    tick(); check("fair_xs_c0", 32'(xs(3)), 32'h0); check("fair_ov_c0", 32'(out_valid), 32'h08);
    check("fair_grant_c0", 32'(grant), 32'h01);
    tick(); check("fair_xs_c1", 32'(xs(3)), 32'h1); check("fair_ov_c1", 32'(out_valid), 32'h08);
    tick(); check("fair_xs_c2", 32'(xs(3)), 32'h2); check("fair_ov_c2", 32'(out_valid), 32'h08);
    tick(); check("fair_xs_c3", 32'(xs(3)), 32'h0); check("fair_ov_c3", 32'(out_valid), 32'h08);

    // Wormhole: input 1 VC1 head to output 2 against input 4 VC0
    do_reset();
    put(1, 1, 2, 1'b0);
    put(4, 0, 2, 1'b1);
    tick();
    check("wh_head_grant", 32'(grant), 32'h02);
    check("wh_head_gvc", 32'(gvc(1)), 32'h1);
    check("wh_head_xs", 32'(xs(2)), 32'h1);
    put(1, 0, 2, 1'b1);
    tick();
    check("wh_body_grant", 32'(grant), 32'h02);
    check("wh_body_gvc", 32'(gvc(1)), 32'h1);
    tail[1*V+1] = 1'b1;
    tick();
    check("wh_tail_grant", 32'(grant), 32'h02);
    check("wh_tail_gvc", 32'(gvc(1)), 32'h1);
    req[1*V+1] = 1'b0;
    tick();
    check("wh_after_grant", 32'(grant), 32'h10);
    check("wh_after_xs", 32'(xs(2)), 32'h4);
    req[4*V+0] = 1'b0;
    tick();
    check("wh_vc0_grant", 32'(grant), 32'h02);
    check("wh_vc0_gvc", 32'(gvc(1)), 32'h0);

    // VC round-robin: input 0 VC0 to output 1, VC1 to output 2
    do_reset();
    put(0, 0, 1, 1'b1);
    put(0, 1, 2, 1'b1);
    tick(); check("vcrr_gvc_c0", 32'(gvc(0)), 32'h0); check("vcrr_ov_c0", 32'(out_valid), 32'h02);
    tick(); check("vcrr_gvc_c1", 32'(gvc(0)), 32'h1); check("vcrr_ov_c1", 32'(out_valid), 32'h04);
    tick(); check("vcrr_gvc_c2", 32'(gvc(0)), 32'h0); check("vcrr_ov_c2", 32'(out_valid), 32'h02);

    // Backpressure on a locked output
    do_reset();
    put(0, 0, 1, 1'b0);
    tick();
    check("bp_head_grant", 32'(grant), 32'h01);
    put(3, 0, 1, 1'b1);
    out_ready[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("bp_stall_grant_%0d", c), 32'(grant), 32'h0);
      check($sformatf("bp_stall_ov_%0d", c), 32'(out_valid), 32'h0);
    end
    out_ready[1] = 1'b1;
    tail[0] = 1'b1;
    tick();
    check("bp_resume_grant", 32'(grant), 32'h01);
    check("bp_resume_xs", 32'(xs(1)), 32'h0);
    req[0] = 1'b0;
    tick();
    check("bp_next_grant", 32'(grant), 32'h08);
    check("bp_next_xs", 32'(xs(1)), 32'h3);

    // Reset mid-packet drops the lock
    do_reset();
    put(0, 0, 4, 1'b0);
    tick();
    check("rlk_head_grant", 32'(grant), 32'h01);
    do_reset();
    put(3, 0, 4, 1'b1);
    tick();
    check("rlk_other_grant", 32'(grant), 32'h08);

    // Bad route on input 2 alongside a good request on input 0
    do_reset();
    put(2, 0, 6, 1'b1);
    put(0, 0, 1, 1'b1);
    tick();
    check("bad_err_set", 32'(route_err), 32'h1);
    check("bad_grant_c0", 32'(grant), 32'h01);
    req[2*V+0] = 1'b0;
    tick();
    check("bad_err_sticky", 32'(route_err), 32'h1);
    check("bad_grant_c1", 32'(grant & 5'b00100), 32'h0);
    clr();
    rst = 1'b0;
    tick();
    check("bad_err_clear", 32'(route_err), 32'h0);
    check("bad_rst_grant", 32'(grant), 32'h0);
    rst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
